// File: rtl/led_ctrl_pkg.sv
// Shared encodings and widths for the breathing-LED sequencer.
// Hold states only exist when LED_BREATH_HOLD_EN is defined.
package led_ctrl_pkg;

  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 32;

  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_RAMP_UP   = 3'd1;
  localparam logic [ST_W-1:0] ST_HOLD_HIGH = 3'd2;
  localparam logic [ST_W-1:0] ST_RAMP_DOWN = 3'd3;
  localparam logic [ST_W-1:0] ST_HOLD_LOW  = 3'd4;

  // States in which the step timer paces duty changes
  function automatic logic is_ramp(input logic [ST_W-1:0] s);
    return (s == ST_RAMP_UP) || (s == ST_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/pwm_cmp.sv
// Free-running PWM period counter with a registered duty compare.
module pwm_cmp
  import led_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] duty,
  output logic             led
);

  localparam logic [CNT_W-1:0] LP_PCNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_pcnt;
  logic             r_led;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
      r_led  <= 1'b0;
    end else begin
      r_led  <= (r_pcnt < duty);
      r_pcnt <= (r_pcnt == LP_PCNT_LAST) ? '0 : r_pcnt + CNT_W'(1);
    end
  end

  assign led = r_led;

endmodule

// File: rtl/led_breath_ctrl.sv
// Breathing-LED sequencer: FSM ramps/holds the duty register feeding pwm_cmp.
// Define LED_BREATH_HOLD_EN to build the HOLD_HIGH/HOLD_LOW states and hold timer.
module led_breath_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD      = 30,
  parameter int unsigned STEP_DIV    = 300,
  parameter int unsigned HOLD_CYCLES = 3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             led,
  output logic [CNT_W-1:0] duty,
  output logic [ST_W-1:0]  state,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LP_DUTY_MAX  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LP_DUTY_PRE  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LP_STEP_LAST = CNT_W'(STEP_DIV - 1);

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_state_nxt;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] w_duty_nxt;
  logic [CNT_W-1:0] r_stmr;
  logic [CNT_W-1:0] w_stmr_nxt;
  logic             r_busy;
  logic             w_step;
  logic             w_ramp;

`ifdef LED_BREATH_HOLD_EN
  localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_htmr;
  logic [CNT_W-1:0] w_htmr_nxt;
  logic             w_hold_done;
`else
  // HOLD_CYCLES has no effect in this build; the empty block only references it
  if (HOLD_CYCLES == 0) begin : g_hold_cycles_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_stmr  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_stmr  <= w_stmr_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef LED_BREATH_HOLD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_htmr <= '0;
    end else begin
      r_htmr <= w_htmr_nxt;
    end
  end
`endif

  // Next-state, duty and timer update; en=0 in RAMP_UP wins over a pending step
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_stmr_nxt  = r_stmr;
    w_ramp      = is_ramp(r_state);
    w_step      = (r_stmr == LP_STEP_LAST);
`ifdef LED_BREATH_HOLD_EN
    w_htmr_nxt  = r_htmr;
    w_hold_done = (r_htmr == LP_HOLD_LAST);
`endif

    case (r_state)
      ST_IDLE: begin
        w_duty_nxt = '0;
        if (en) begin
          w_state_nxt = ST_RAMP_UP;
        end
      end

      ST_RAMP_UP: begin
        if (!en) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (w_step) begin
          if (r_duty >= LP_DUTY_PRE) begin
            w_duty_nxt  = LP_DUTY_MAX;
`ifdef LED_BREATH_HOLD_EN
            w_state_nxt = ST_HOLD_HIGH;
`else
            w_state_nxt = ST_RAMP_DOWN;
`endif
          end else begin
            w_duty_nxt = r_duty + CNT_W'(1);
          end
        end
      end

      ST_RAMP_DOWN: begin
        if (w_step) begin
          if (r_duty <= CNT_W'(1)) begin
            w_duty_nxt = '0;
`ifdef LED_BREATH_HOLD_EN
            w_state_nxt = en ? ST_HOLD_LOW : ST_IDLE;
`else
            w_state_nxt = en ? ST_RAMP_UP : ST_IDLE;
`endif
          end else begin
            w_duty_nxt = r_duty - CNT_W'(1);
          end
        end
      end

`ifdef LED_BREATH_HOLD_EN
      ST_HOLD_HIGH: begin
        if (!en || w_hold_done) begin
          w_state_nxt = ST_RAMP_DOWN;
        end
      end

      ST_HOLD_LOW: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hold_done) begin
          w_state_nxt = ST_RAMP_UP;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_duty_nxt  = '0;
      end
`else
      ST_HOLD_HIGH, ST_HOLD_LOW: begin
        w_state_nxt = ST_IDLE;
        w_duty_nxt  = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_duty_nxt  = '0;
      end
`endif
    endcase

    // Timers restart on any state change and only run in their own states
    if (w_state_nxt != r_state) begin
      w_stmr_nxt = '0;
    end else if (w_ramp) begin
      w_stmr_nxt = w_step ? '0 : r_stmr + CNT_W'(1);
    end else begin
      w_stmr_nxt = '0;
    end

`ifdef LED_BREATH_HOLD_EN
    if (w_state_nxt != r_state) begin
      w_htmr_nxt = '0;
    end else if ((r_state == ST_HOLD_HIGH) || (r_state == ST_HOLD_LOW)) begin
      w_htmr_nxt = r_htmr + CNT_W'(1);
    end else begin
      w_htmr_nxt = '0;
    end
`endif
  end

  pwm_cmp #(
    .PERIOD (PERIOD)
  ) u_pwm_cmp (
    .clk  (clk),
    .rst  (rst),
    .duty (r_duty),
    .led  (led)
  );

  assign duty  = r_duty;
  assign state = r_state;
  assign busy  = r_busy;

endmodule
